// File: rtl/inst_seq_if.sv
// -----------------------------------------------------------------------------
// inst_seq_if : handshake bundle between the instruction sequencer and its
// neighbours.
//   load_valid / load_data / load_ready : program-word load channel
//   out_valid  / out_inst  / out_ready  : instruction replay channel to the core
// Modports:
//   slave  : the sequencer (accepts loads, drives instructions)
//   master : the environment (offers loads, consumes instructions)
// -----------------------------------------------------------------------------
interface inst_seq_if #(
    parameter int INST_W = 16
);
    logic              load_valid;
    logic [INST_W-1:0] load_data;
    logic              load_ready;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_inst
    );

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_inst
    );
endinterface

// File: rtl/inst_seq.sv
// -----------------------------------------------------------------------------
// inst_seq : instruction sequencer feeding an 8-bit CPU core.
// Program words are buffered into a DEPTH-entry store while IDLE, then replayed
// in order (one word per accepted transfer) after a start pulse. Replay ends at
// the end of the program or at a HALT word (opcode 4'b0111), which is never
// presented to the core.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : load channel + instruction channel (see inst_seq_if)
//   i_start       : begin replay from index 0 (pulse)
//   i_clear       : discard program, return to IDLE (pulse, highest priority)
//   o_pc          : store index of the word currently in out_inst
//   o_prog_len    : number of words stored (can represent DEPTH)
//   o_busy        : state is RUN
//   o_done        : state is DONE
//
// Build option: define INST_SEQ_LOOP_EN to replay the program indefinitely
// (end of program wraps to index 0; only HALT or clear ends the run).
// -----------------------------------------------------------------------------
module inst_seq #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    inst_seq_if.slave                bus,
    input  logic                     i_start,
    input  logic                     i_clear,
    output logic [$clog2(DEPTH)-1:0] o_pc,
    output logic [$clog2(DEPTH):0]   o_prog_len,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int AW = $clog2(DEPTH);
`ifdef INST_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam logic [3:0] HALT_OP = 4'b0111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [INST_W-1:0] r_mem [DEPTH];
    logic [INST_W-1:0] r_out_inst;
    logic              r_out_valid;
    logic [AW-1:0]     r_pc;
    logic [AW:0]       r_prog_len;

    logic              w_load, w_xfer, w_go, w_last, w_end;
    logic [AW-1:0]     w_nidx;
    logic [INST_W-1:0] w_nword, w_m0;
    logic              w_nhalt, w_m0_halt;

    assign w_load    = bus.load_valid && bus.load_ready;
    assign w_xfer    = r_out_valid && bus.out_ready;
    assign w_go      = i_start && (r_prog_len != '0);
    // Current word is the last one of the program.
    assign w_last    = ((AW+1)'(r_pc) + 1'b1) == r_prog_len;
    // End of program only terminates the run when looping is disabled.
    assign w_end     = w_last && !LOOP;
    // Index of the word that follows a transfer; wraps to 0 after the last
    // word (only used that way in loop mode). pc arithmetic is modulo DEPTH.
    assign w_nidx    = w_last ? '0 : r_pc + 1'b1;
    assign w_nword   = r_mem[w_nidx];
    assign w_nhalt   = w_nword[INST_W-1 -: 4] == HALT_OP;
    assign w_m0      = r_mem[0];
    assign w_m0_halt = w_m0[INST_W-1 -: 4] == HALT_OP;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nx = r_state;
        if (i_clear) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Empty program or HALT at index 0 finishes with no transfers.
                    if (i_start)
                        w_state_nx = (!w_go || w_m0_halt) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (w_xfer && (w_end || w_nhalt)) w_state_nx = S_DONE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy         = (r_state == S_RUN);
        o_done         = (r_state == S_DONE);
        bus.load_ready = rst_n && (r_state == S_IDLE) &&
                         (r_prog_len < (AW+1)'(DEPTH)) && !i_start && !i_clear;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_pc        <= '0;
            r_prog_len  <= '0;
        end else if (i_clear) begin
            // A transfer pending in this cycle is dropped, not consumed.
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_pc        <= '0;
            r_prog_len  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_pc        <= '0;
                        r_out_valid <= !w_m0_halt;
                        if (!w_m0_halt) r_out_inst <= w_m0;
                    end else if (w_load) begin
                        r_prog_len <= r_prog_len + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (w_end || w_nhalt) begin
                            // pc keeps the last transferred index.
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_inst <= w_nword;
                            r_pc       <= w_nidx;
                        end
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    // Program store: not reset.
    always_ff @(posedge clk) begin
        if (w_load) r_mem[r_prog_len[AW-1:0]] <= bus.load_data;
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign o_pc          = r_pc;
    assign o_prog_len    = r_prog_len;
endmodule

// File: tb/tb_inst_seq.sv
// -----------------------------------------------------------------------------
// tb_inst_seq : self-checking bench for inst_seq (DEPTH=16, INST_W=16).
// Table-driven programs, hand-written corner sequences and randomized programs
// with random back-pressure, checked against a reference model that derives
// the expected transfer list directly from the program contents.
// -----------------------------------------------------------------------------
module tb_inst_seq;
`ifdef INST_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int LIM = 40;   // transfer cap for runs that never end

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, i_clear;
    logic [3:0] o_pc;
    logic [4:0] o_prog_len;
    logic       o_busy, o_done;

    inst_seq_if #(.INST_W(16)) bus ();

    inst_seq #(.DEPTH(16), .INST_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .i_start(i_start), .i_clear(i_clear),
        .o_pc(o_pc), .o_prog_len(o_prog_len),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [15:0] prog[$], exp_w[$], obs_w[$];
    int          exp_pc[$], obs_pc[$];
    bit          exp_fin;

    typedef struct {
        int              n;
        logic [3:0][15:0] w;     // w[0] is the first program word
        int              mode;   // 0: always ready, 1: toggle, 2: random
        int              exp_n;  // transfers expected, plain build
        int              exp_l;  // transfers expected, loop build
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        i_clear = 1'b1; tick(); i_clear = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[i]) begin
            bus.load_valid = 1'b1; bus.load_data = prog[i]; tick();
        end
        bus.load_valid = 1'b0;
    endtask

    // Reference: the program is walked from index 0; a HALT word ends it
    // before being shown; the end of the program ends it unless looping.
    function automatic void model(input int lim);
        int k;
        exp_w.delete(); exp_pc.delete(); exp_fin = 1'b1;
        for (int i = 0; prog.size() > 0; i++) begin
            if (!LOOP && i == prog.size()) break;
            k = i % prog.size();
            if (prog[k][15:12] == 4'h7) break;
            if (exp_w.size() == lim) begin exp_fin = 1'b0; break; end
            exp_w.push_back(prog[k]); exp_pc.push_back(k);
        end
    endfunction

    task automatic run_prog(input int mode, input int lim);
        int cyc, last_x, done_cyc;
        bit pv, pr;
        logic [15:0] pinst;
        logic [3:0]  ppc;
        obs_w.delete(); obs_pc.delete();
        pv = 1'b0; pr = 1'b0; pinst = '0; ppc = '0;
        last_x = -1; done_cyc = -1;
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cyc == 0) chk("start_to_valid", bus.out_valid, exp_w.size() > 0);
            if (pv && !pr) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_inst", bus.out_inst, pinst);
                chk("stall_pc", o_pc, ppc);
            end
            chk("halt_never_shown", bus.out_valid && bus.out_inst[15:12] == 4'h7, 0);
            pv = bus.out_valid; pr = bus.out_ready; pinst = bus.out_inst; ppc = o_pc;
            if (bus.out_valid && bus.out_ready) begin
                obs_w.push_back(bus.out_inst); obs_pc.push_back(int'(o_pc)); last_x = cyc;
            end
            if (o_done) begin done_cyc = cyc; break; end
            if (obs_w.size() == lim) break;
            tick();
        end
        if (exp_fin) begin
            chk("done_after_last", done_cyc, last_x + 1);
            chk("done_out_valid0", bus.out_valid, 0);
        end else begin
            chk("loop_done_low", o_done, 0);
            chk("loop_busy", o_busy, 1);
        end
        chk("xfer_count", obs_w.size(), exp_w.size());
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            chk("xfer_word", obs_w[i], exp_w[i]);
            chk("xfer_pc", obs_pc[i], exp_pc[i]);
        end
        tick();
    endtask

    initial begin
        logic [15:0] w;
        int len;
        tbl[0] = '{3, {16'h0000, 16'h2B00, 16'h0AB0, 16'h1A05}, 0, 3, LIM};
        tbl[1] = '{3, {16'h0000, 16'h2B00, 16'h0AB0, 16'h1A05}, 1, 3, LIM};
        tbl[2] = '{3, {16'h0000, 16'h2300, 16'h7000, 16'h1305}, 0, 1, 1};
        tbl[3] = '{2, {16'h0000, 16'h0000, 16'h1111, 16'h7000}, 0, 0, 0};
        tbl[4] = '{0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 0};
        tbl[5] = '{4, {16'h7ABC, 16'h3333, 16'h2222, 16'h1111}, 2, 3, 3};
        tbl[6] = '{2, {16'h0000, 16'h0000, 16'hB100, 16'h1101}, 0, 2, LIM};

        // ---- reset ----
        rst_n = 1'b0; i_start = 1'b0; i_clear = 1'b0;
        bus.load_valid = 1'b1; bus.load_data = 16'h1234; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_load_ready", bus.load_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_prog_len", o_prog_len, 0);
        chk("rst_busy_done", {o_busy, o_done}, 0);
        tick(); bus.load_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("idle_load_ready", bus.load_ready, 1);
        chk("idle_prog_len", o_prog_len, 0);
        tick();

        // ---- table-driven programs ----
        foreach (tbl[t]) begin
            do_clear();
            prog.delete();
            for (int i = 0; i < tbl[t].n; i++) prog.push_back(tbl[t].w[i]);
            load_prog();
            @(negedge clk);
            chk("tbl_prog_len", o_prog_len, tbl[t].n);
            tick();
            model(LIM);
            run_prog(tbl[t].mode, LIM);
            chk("tbl_xfers", obs_w.size(), LOOP ? tbl[t].exp_l : tbl[t].exp_n);
        end

        // ---- full store: 17th word dropped, replay all 16 ----
        do_clear();
        prog.delete();
        for (int i = 0; i < 16; i++) prog.push_back(16'h1000 + 16'(i * 16'h0111));
        load_prog();
        @(negedge clk);
        chk("full_prog_len", o_prog_len, 16);
        chk("full_load_ready", bus.load_ready, 0);
        tick();
        bus.load_valid = 1'b1; bus.load_data = 16'hDEAD; tick(); bus.load_valid = 1'b0;
        @(negedge clk);
        chk("drop17_prog_len", o_prog_len, 16);
        tick();
        model(LIM);
        run_prog(0, LIM);

        // ---- clear mid-RUN with a transfer pending ----
        do_clear();
        prog.delete();
        prog.push_back(16'h1A05); prog.push_back(16'h0AB0); prog.push_back(16'h2B00);
        load_prog();
        bus.out_ready = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        @(negedge clk);
        chk("run_busy", o_busy, 1);
        chk("run_valid_stalled", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b1; i_clear = 1'b1; tick(); i_clear = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", bus.out_valid, 0);
        chk("clr_prog_len", o_prog_len, 0);
        chk("clr_pc", o_pc, 0);
        chk("clr_busy_done", {o_busy, o_done}, 0);
        chk("clr_load_ready", bus.load_ready, 1);
        tick();

        // ---- asynchronous reset mid-RUN ----
        load_prog();
        i_start = 1'b1; tick(); i_start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_prog_len", o_prog_len, 0);
        chk("arst_busy", o_busy, 0);
        tick(); rst_n = 1'b1; tick();

        // ---- randomized programs with random back-pressure ----
        for (int r = 0; r < 24; r++) begin
            do_clear();
            prog.delete();
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 5) == 0) w[15:12] = 4'h7;
                else if (w[15:12] == 4'h7) w[15:12] = 4'h8;
                prog.push_back(w);
            end
            load_prog();
            @(negedge clk);
            chk("rnd_prog_len", o_prog_len, len);
            tick();
            model(LIM);
            run_prog(2, LIM);
            // Replay from DONE without reloading.
            if (exp_fin) run_prog(2, LIM);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
